// File: rtl/conv_window_addr_gen.sv
// 3x3 convolution window address generator: one window of K*K packed tap addresses per
// accepted handshake, scanning a row-major feature map with stride 1 and no padding.
module conv_window_addr_gen #(
  parameter int unsigned array_size = 9,
  parameter int unsigned K          = 3,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [6:0]                   img_width,
  input  logic [6:0]                   img_height,
  input  logic                         addr_ready,
  output logic [ADDR_W*array_size-1:0] addr_out,
  output logic                         addr_valid,
  output logic                         busy,
  output logic                         done
);

  localparam logic [6:0] KDim = 7'(K);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                        state_q, state_d;
  logic [6:0]                    w_q, w_d;
  logic [6:0]                    h_q, h_d;
  logic [6:0]                    ox_q, ox_d;
  logic [6:0]                    oy_q, oy_d;
  // Address of pixel (oy, 0); advanced by W per output row instead of multiplying.
  logic [ADDR_W-1:0]             row_q, row_d;
  logic [ADDR_W*array_size-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]             tap_row;
  logic [ADDR_W-1:0]             w_ext;
  logic                          load;
  logic                          last_win;

  assign last_win = (ox_q == w_q - KDim) && (oy_q == h_q - KDim);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    row_d   = row_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d = img_width;
          h_d = img_height;
          if (img_width >= KDim && img_height >= KDim) begin
            state_d = StRun;
            ox_d    = '0;
            oy_d    = '0;
            row_d   = base_addr;
            load    = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (addr_ready) begin
          if (last_win) begin
            state_d = StDone;
          end else begin
            load = 1'b1;
            if (ox_q == w_q - KDim) begin
              ox_d  = '0;
              oy_d  = oy_q + 7'd1;
              row_d = row_q + {{(ADDR_W-7){1'b0}}, w_q};
            end else begin
              ox_d = ox_q + 7'd1;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Tap addresses of the next window, built by accumulating W down the kernel rows.
  always_comb begin
    addr_d  = addr_q;
    w_ext   = {{(ADDR_W-7){1'b0}}, w_d};
    tap_row = row_d + ADDR_W'(ox_d);
    if (load) begin
      for (int ky = 0; ky < int'(K); ky++) begin
        for (int kx = 0; kx < int'(K); kx++) begin
          addr_d[(ky*int'(K)+kx)*int'(ADDR_W) +: ADDR_W] = tap_row + ADDR_W'(kx);
        end
        tap_row = tap_row + w_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      w_q     <= '0;
      h_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = (state_q == StRun);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule
